spi_reg_responder: RTL and testbench

SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

---
 rtl/spi_pkg.sv | 8 +
 rtl/spi_reg_responder_if.sv | 9 +
 rtl/spi_reg_responder_sync2.sv | 12 +
 rtl/spi_reg_responder.sv | 99 +++++++++
 tb/tb_spi_reg_responder.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, frame length and responder state encoding.
package spi_pkg;
    localparam int DWIDTH = 8;
    localparam int AWIDTH = 4;
    localparam int FRAME_LEN = 1 + AWIDTH + DWIDTH;
    localparam int CW = $clog2(FRAME_LEN);
    typedef enum logic [2:0] {WAIT_IDLE, IDLE, HEADER, DATA, DONE} spi_rsp_state_t;
endpackage

// File: rtl/spi_reg_responder_if.sv
// spi_reg_responder_if: SPI pin bundle between an SPI master and the responder.
interface spi_reg_responder_if;
    logic sck;
    logic mosi;
    logic ss_n;
    logic miso;
    modport master (output sck, mosi, ss_n, input miso);
    modport slave (input sck, mosi, ss_n, output miso);
endinterface

// File: rtl/spi_reg_responder_sync2.sv
// spi_sync2: two-flop synchronizer with a configurable reset value.
module spi_sync2 #(parameter logic RST_VAL = 1'b0) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, m} <= {RST_VAL, RST_VAL};
        else {q, m} <= {m, d};
endmodule

// File: rtl/spi_reg_responder.sv
// spi_reg_responder: SPI slave exposing a register bank; frames are RW, address, data, MSB first.
module spi_reg_responder
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        driver_cfg,
    spi_reg_responder_if.slave spi,
    input  logic [AWIDTH-1:0] host_addr,
    output logic [DWIDTH-1:0] host_rdata,
    output logic              wr_strobe,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [DWIDTH-1:0] wr_data,
    output logic              rd_strobe,
    output logic              busy,
    output logic              frame_err
);
    spi_rsp_state_t state, state_nxt;
    logic sck_s, mosi_s, ss_s, sck_d, ss_d, rw, miso_q;
    logic [1:0] cfg;
    logic [CW-1:0] cnt;
    logic [AWIDTH-1:0] addr, addr_now;
    logic [DWIDTH-1:0] rx, tx_sr, word_now;
    logic [DWIDTH-1:0] bank [2**AWIDTH];

    spi_sync2 #(.RST_VAL(1'b0)) u_sck  (.clk(clk), .rst(rst), .d(spi.sck),  .q(sck_s));
    spi_sync2 #(.RST_VAL(1'b0)) u_mosi (.clk(clk), .rst(rst), .d(spi.mosi), .q(mosi_s));
    spi_sync2 #(.RST_VAL(1'b1)) u_ss   (.clk(clk), .rst(rst), .d(spi.ss_n), .q(ss_s));

    wire rise = sck_s & ~sck_d;
    wire fall = ~sck_s & sck_d;
    wire ss_fall = ~ss_s & ss_d;
    wire ss_rise = ss_s & ~ss_d;
    wire lead = cfg[1] ? fall : rise;
    wire trail = cfg[1] ? rise : fall;
    wire samp = cfg[0] ? trail : lead;
    wire shft = cfg[0] ? lead : trail;
    wire abort = (state == HEADER || state == DATA) && ss_rise;
    wire last_addr = state == HEADER && samp && !ss_rise && cnt == CW'(AWIDTH);
    wire commit = state == DATA && samp && !ss_rise && cnt == CW'(FRAME_LEN - 1);

    assign addr_now = {addr[AWIDTH-2:0], mosi_s};
    assign word_now = {rx[DWIDTH-2:0], mosi_s};
    assign host_rdata = bank[host_addr];
    assign spi.miso = miso_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= WAIT_IDLE;
        else state <= state_nxt;

    // WAIT_IDLE holds off until the ss_n synchronizer has flushed its reset value.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_IDLE: state_nxt = (cnt == CW'(3) && ss_s) ? IDLE : WAIT_IDLE;
            IDLE:      state_nxt = ss_fall ? HEADER : IDLE;
            HEADER:    state_nxt = abort ? IDLE : last_addr ? DATA : HEADER;
            DATA:      state_nxt = abort ? IDLE : commit ? DONE : DATA;
            DONE:      state_nxt = ss_rise ? IDLE : DONE;
            default:   state_nxt = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            {sck_d, ss_d, rw, miso_q, busy, wr_strobe, rd_strobe, frame_err} <= 8'b0100_0000;
            {cfg, cnt, addr, rx, tx_sr, wr_addr, wr_data} <= '0;
            bank <= '{default: '0};
        end else begin
            sck_d <= sck_s;
            ss_d <= ss_s;
            busy <= state_nxt != IDLE;
            wr_strobe <= commit && rw;
            rd_strobe <= last_addr && !rw;
            frame_err <= abort;
            miso_q <= (state == DATA && !rw) ? (shft ? tx_sr[DWIDTH-1] : miso_q) : 1'b0;
            if (state == DATA && shft) tx_sr <= {tx_sr[DWIDTH-2:0], 1'b0};
            if (last_addr && !rw) tx_sr <= bank[addr_now];
            if (state == WAIT_IDLE && cnt != CW'(3)) cnt <= cnt + 1'b1;
            if (state == IDLE && ss_fall) begin
                cnt <= '0;
                cfg <= driver_cfg;
            end
            if (state == HEADER && samp) begin
                cnt <= cnt + 1'b1;
                if (cnt == '0) rw <= mosi_s;
                else addr <= addr_now;
            end
            if (state == DATA && samp) begin
                cnt <= cnt + 1'b1;
                rx <= word_now;
            end
            if (commit && rw) begin
                bank[addr] <= word_now;
                wr_addr <= addr;
                wr_data <= word_now;
            end
        end
endmodule

// File: tb/tb_spi_reg_responder.sv
// tb_spi_reg_responder: bit-banged SPI master with a scoreboard on writes, errors and read data.
module tb_spi_reg_responder;
    import spi_pkg::*;
    localparam int HP = 80;

    logic clk = 0, rst = 1;
    logic [1:0] driver_cfg = 0;
    logic [AWIDTH-1:0] host_addr = 0;
    logic [DWIDTH-1:0] host_rdata, wr_data;
    logic [AWIDTH-1:0] wr_addr;
    logic wr_strobe, rd_strobe, busy, frame_err;
    int total = 0, bad = 0, rd_seen = 0, rd_exp = 0;
    logic [11:0] exp_wr[$];
    int exp_err[$];
    logic [7:0] exp_rd[$];
    logic [7:0] rd;

    spi_reg_responder_if s();
    spi_reg_responder dut (.clk(clk), .rst(rst), .driver_cfg(driver_cfg), .spi(s.slave),
        .host_addr(host_addr), .host_rdata(host_rdata), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_strobe(rd_strobe), .busy(busy), .frame_err(frame_err));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        if (wr_strobe) begin
            if (exp_wr.size() == 0) chk("wr_unexpected", 32'(wr_addr), 32'hFFFF);
            else begin
                logic [11:0] e;
                e = exp_wr.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e[11:8]));
                chk("wr_data", 32'(wr_data), 32'(e[7:0]));
            end
        end
        if (frame_err) begin
            if (exp_err.size() == 0) chk("err_unexpected", 1, 0);
            else void'(exp_err.pop_front());
        end
        if (rd_strobe) rd_seen++;
    end

    task automatic frame(input logic [1:0] mode, input logic rw, input logic [3:0] a,
                         input logic [7:0] d, input int nbits, input int extra, input int rst_at,
                         output logic [7:0] q);
        logic [12:0] fb;
        fb = {rw, a, d};
        q = 0;
        driver_cfg = mode;
        s.sck = mode[1];
        s.mosi = 0;
        #HP s.ss_n = 0;
        #HP;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1;
                #20 rst = 0;
            end
            if (!mode[0]) begin
                s.mosi = fb[12-i];
                #HP s.sck = ~mode[1];
                if (i >= 5) q = {q[6:0], s.miso};
                #HP s.sck = mode[1];
            end else begin
                s.sck = ~mode[1];
                s.mosi = fb[12-i];
                #HP s.sck = mode[1];
                if (i >= 5) q = {q[6:0], s.miso};
                #HP;
            end
        end
        for (int i = 0; i < extra; i++) begin
            #HP s.sck = ~mode[1];
            #HP s.sck = mode[1];
        end
        #HP chk("busy_in_frame", 32'(busy), 1);
        s.ss_n = 1;
        #(4*HP) chk("busy_after_ss", 32'(busy), 0);
    endtask

    task automatic wr(input logic [1:0] mode, input logic [3:0] a, input logic [7:0] d);
        exp_wr.push_back({a, d});
        frame(mode, 1'b1, a, d, FRAME_LEN, 0, -1, rd);
    endtask

    task automatic rdchk(input logic [1:0] mode, input logic [3:0] a, input logic [7:0] e);
        exp_rd.push_back(e);
        rd_exp++;
        frame(mode, 1'b0, a, 8'h00, FRAME_LEN, 0, -1, rd);
        chk($sformatf("miso_m%0d_a%0h", mode, a), 32'(rd), 32'(exp_rd.pop_front()));
    endtask

    initial begin
        s.sck = 0;
        s.mosi = 0;
        s.ss_n = 1;
        #20;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_miso", 32'(s.miso), 0);
        chk("rst_wr_strobe", 32'(wr_strobe), 0);
        chk("rst_rd_strobe", 32'(rd_strobe), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        rst = 0;
        #100 chk("idle_busy", 32'(busy), 0);

        wr(2'd0, 4'h3, 8'hA5);
        host_addr = 4'h3;
        #10 chk("host_rdata_3", 32'(host_rdata), 32'hA5);
        rdchk(2'd0, 4'h3, 8'hA5);
        for (int m = 1; m < 4; m++) begin
            wr(2'(m), 4'h1, 8'h5A);
            rdchk(2'(m), 4'h1, 8'h5A);
        end

        exp_err.push_back(1);
        frame(2'd0, 1'b1, 4'h2, 8'hFF, 8, 0, -1, rd);
        host_addr = 4'h2;
        #10 chk("host_rdata_2_abort", 32'(host_rdata), 0);

        exp_wr.push_back({4'h4, 8'h3C});
        frame(2'd0, 1'b1, 4'h4, 8'h3C, FRAME_LEN, 4, -1, rd);
        rdchk(2'd3, 4'h4, 8'h3C);

        frame(2'd0, 1'b1, 4'h5, 8'hEE, FRAME_LEN, 0, 7, rd);
        for (int a = 0; a < 16; a++) begin
            host_addr = 4'(a);
            #10 chk($sformatf("host_rdata_rst_%0h", a), 32'(host_rdata), 0);
        end
        for (int a = 0; a < 16; a++) rdchk(2'd0, 4'(a), 8'h00);
        wr(2'd0, 4'h5, 8'h77);
        rdchk(2'd1, 4'h5, 8'h77);

        #(4*HP);
        chk("wr_left", 32'(exp_wr.size()), 0);
        chk("err_left", 32'(exp_err.size()), 0);
        chk("rd_strobes", 32'(rd_seen), 32'(rd_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
